aq_djpeg_hm_bitfeed: RTL

//  Entropy-coded-segment bit feeder, directly upstream of the Huffman decode stage.
//  - Takes 32-bit words of raw JPEG scan data and removes 0xFF00 byte stuffing.
//  - Detects RSTn and EOI markers.
//  - Presents a 32-bit, MSB-aligned bit window on DataOut/DataOutEnable.
//  - Advances the window by DecodeUseWidth bits on each DecodeUseBit pulse.
//  - Discards bits up to the next byte boundary on DecodeAlignByte.

---
 rtl/aq_djpeg_pkg.sv | 29 ++
 rtl/aq_djpeg_unstuff.sv | 131 +++++++++++++
 rtl/aq_djpeg_hm_bitfeed.sv | 105 ++++++++++
 3 files changed

// File: rtl/aq_djpeg_pkg.sv
// Shared JPEG scan constants: marker bytes, unstuffer states, byte push payload.
package aq_djpeg_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned USE_W  = 7;

    localparam logic [7:0] MK_FF    = 8'hFF;
    localparam logic [7:0] MK_STUFF = 8'h00;
    localparam logic [7:0] MK_RST0  = 8'hD0;
    localparam logic [7:0] MK_RST7  = 8'hD7;
    localparam logic [7:0] MK_EOI   = 8'hD9;

    typedef enum logic {
        S_DATA = 1'b0,
        S_FF   = 1'b1
    } us_state_e;

    typedef struct packed {
        logic              valid;
        logic [BYTE_W-1:0] data;
    } byte_push_t;

    // True for RST0..RST7 marker codes
    function automatic logic is_rst_marker(input logic [7:0] b);
        return (b >= MK_RST0) && (b <= MK_RST7);
    endfunction

endpackage

// File: rtl/aq_djpeg_unstuff.sv
// Input word register plus byte-serial 0xFF00 unstuffer and marker detector.
module aq_djpeg_unstuff
    import aq_djpeg_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready_c,
    input  logic              byte_ready,
    output byte_push_t        push_c,
    input  logic              align,
    output logic              rst_pending,
    output logic              eoi,
    output logic              marker_err,
    output logic              rst_pending_nxt_c,
    output logic              eoi_nxt_c
);

    logic [WORD_W-1:0] word_q;
    logic [1:0]        idx_q;
    logic              full_q;
    logic              live_q;
    us_state_e         state_q;
    us_state_e         state_d;
    logic              pend_d;
    logic              eoi_d;
    logic              merr_d;
    logic [BYTE_W-1:0] cur_byte;
    logic              step;
    logic              drop;
    logic              issue;
    logic              accept;

    assign cur_byte   = word_q[{~idx_q, 3'b000} +: BYTE_W];
    assign step       = full_q & byte_ready & ~rst_pending & ~eoi;
    assign drop       = full_q & eoi;
    assign issue      = step | drop;
    assign in_ready_c = live_q & ~init & (~full_q | (issue & (idx_q == 2'd3)));
    assign accept     = in_valid & in_ready_c;

    assign rst_pending_nxt_c = pend_d;
    assign eoi_nxt_c         = eoi_d;

    // Word register: holds one word and walks its bytes, reloading without a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            idx_q  <= '0;
            full_q <= 1'b0;
            live_q <= 1'b0;
        end else if (init) begin
            word_q <= '0;
            idx_q  <= '0;
            full_q <= 1'b0;
            live_q <= 1'b1;
        end else begin
            live_q <= 1'b1;
            if (accept) begin
                word_q <= in_data;
                idx_q  <= '0;
                full_q <= 1'b1;
            end else if (issue) begin
                if (idx_q == 2'd3) begin
                    full_q <= 1'b0;
                end
                idx_q <= idx_q + 2'd1;
            end
        end
    end

    // Unstuffer state and sticky marker flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_DATA;
            rst_pending <= 1'b0;
            eoi         <= 1'b0;
            marker_err  <= 1'b0;
        end else if (init) begin
            state_q     <= S_DATA;
            rst_pending <= 1'b0;
            eoi         <= 1'b0;
            marker_err  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_pending <= pend_d;
            eoi         <= eoi_d;
            marker_err  <= merr_d;
        end
    end

    // Next state, byte push and marker decode; FF fill bytes keep us in S_FF
    always_comb begin
        state_d     = state_q;
        pend_d      = rst_pending & ~align;
        eoi_d       = eoi;
        merr_d      = marker_err;
        push_c      = '0;
        if (step) begin
            case (state_q)
                S_DATA: begin
                    if (cur_byte == MK_FF) begin
                        state_d = S_FF;
                    end else begin
                        push_c.valid = 1'b1;
                        push_c.data  = cur_byte;
                    end
                end
                S_FF: begin
                    state_d = S_DATA;
                    if (cur_byte == MK_STUFF) begin
                        push_c.valid = 1'b1;
                        push_c.data  = MK_FF;
                    end else if (cur_byte == MK_FF) begin
                        state_d = S_FF;
                    end else if (is_rst_marker(cur_byte)) begin
                        pend_d = 1'b1;
                    end else if (cur_byte == MK_EOI) begin
                        eoi_d = 1'b1;
                    end else begin
                        merr_d = 1'b1;
                        eoi_d  = 1'b1;
                    end
                end
                default: state_d = S_DATA;
            endcase
        end
    end

endmodule

// File: rtl/aq_djpeg_hm_bitfeed.sv
// Bit feeder for the Huffman decoder: MSB-aligned bit buffer with 32-bit window.
module aq_djpeg_hm_bitfeed
    import aq_djpeg_pkg::*;
#(
    parameter int unsigned BUF_W = 64
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ProcessInit,
    input  logic              ScanInValid,
    input  logic [WORD_W-1:0] ScanInData,
    output logic              ScanInReady,
    input  logic              DecodeUseBit,
    input  logic [USE_W-1:0]  DecodeUseWidth,
    input  logic              DecodeAlignByte,
    output logic              DataOutEnable,
    output logic [WORD_W-1:0] DataOut,
    output logic              RstMarkerPending,
    output logic              EoiDetect,
    output logic              MarkerError
);

    localparam int unsigned CNT_W = $clog2(BUF_W + 1);
    localparam logic [BUF_W-1:0] TOP_MASK = {{BYTE_W{1'b1}}, {(BUF_W-BYTE_W){1'b0}}};

    logic [BUF_W-1:0] buf_q;
    logic [BUF_W-1:0] buf_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             byte_ready;
    byte_push_t       push_c;
    logic             pend_nxt_c;
    logic             eoi_nxt_c;
    logic             use_ok;

    // Shift left by n, refilling vacated LSBs with the JPEG pad value (1s)
    function automatic logic [BUF_W-1:0] shl_ones(input logic [BUF_W-1:0] v,
                                                  input logic [USE_W-1:0] n);
        logic [2*BUF_W-1:0] t;
        t = {v, {BUF_W{1'b1}}} << n;
        return t[2*BUF_W-1:BUF_W];
    endfunction

    assign byte_ready = cnt_q <= CNT_W'(BUF_W - BYTE_W);
    assign use_ok     = DecodeUseBit & DataOutEnable & (DecodeUseWidth != '0) &
                        (DecodeUseWidth <= USE_W'(WORD_W));

    aq_djpeg_unstuff u_unstuff (
        .clk               (clk),
        .rst_n             (rst),
        .init              (ProcessInit),
        .in_valid          (ScanInValid),
        .in_data           (ScanInData),
        .in_ready_c        (ScanInReady),
        .byte_ready        (byte_ready),
        .push_c            (push_c),
        .align             (DecodeAlignByte),
        .rst_pending       (RstMarkerPending),
        .eoi               (EoiDetect),
        .marker_err        (MarkerError),
        .rst_pending_nxt_c (pend_nxt_c),
        .eoi_nxt_c         (eoi_nxt_c)
    );

    // Buffer update order: consume, then byte-align, then append the pushed byte
    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (use_ok) begin
            buf_d = shl_ones(buf_d, DecodeUseWidth);
            cnt_d = (CNT_W'(DecodeUseWidth) > cnt_d) ? '0 : cnt_d - CNT_W'(DecodeUseWidth);
        end
        if (DecodeAlignByte) begin
            buf_d = shl_ones(buf_d, USE_W'(cnt_d[2:0]));
            cnt_d = cnt_d & ~CNT_W'(7);
        end
        if (push_c.valid) begin
            buf_d = (buf_d & ~(TOP_MASK >> cnt_d)) |
                    ({push_c.data, {(BUF_W-BYTE_W){1'b0}}} >> cnt_d);
            cnt_d = cnt_d + CNT_W'(BYTE_W);
        end
    end

    // Buffer, bit count and registered output window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q         <= '1;
            cnt_q         <= '0;
            DataOut       <= '0;
            DataOutEnable <= 1'b0;
        end else if (ProcessInit) begin
            buf_q         <= '1;
            cnt_q         <= '0;
            DataOut       <= '0;
            DataOutEnable <= 1'b0;
        end else begin
            buf_q         <= buf_d;
            cnt_q         <= cnt_d;
            DataOut       <= buf_d[BUF_W-1 -: WORD_W];
            DataOutEnable <= (cnt_d >= CNT_W'(WORD_W)) | pend_nxt_c | eoi_nxt_c;
        end
    end

endmodule
